// File: rtl/fir_pkg.sv
// Shared constants and coefficient-FSM encoding for the FIR front end.
package fir_pkg;

  localparam int FIR_NUM_TAP = 10;
  localparam int FIR_DATA_W  = 16;
  localparam int FIR_CLK_DIV = 40;
  localparam int FIR_ADDR_W  = 4;

  // Coefficient FSM encoding, kept as plain constants for legacy tools.
  localparam logic [0:0] COEFF_IDLE    = 1'b0;
  localparam logic [0:0] COEFF_PENDING = 1'b1;

  // True when a coefficient address selects a real tap.
  function automatic logic tap_in_range(input int addr, input int num_tap);
    return (addr >= 0) && (addr < num_tap);
  endfunction

endpackage

// File: rtl/fir_sample_strobe_gen.sv
// Sample-rate divider: counts 0..CLK_DIV-1 and emits a one-cycle strobe
// in the cycle following the boundary edge (counter == CLK_DIV-2).
module fir_sample_strobe_gen
  import fir_pkg::*;
#(
  parameter int CLK_DIV = FIR_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic boundary,
  output logic en_sample
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BOUND = CNT_W'(CLK_DIV - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_sample_q, en_sample_d;

  // The edge that samples cnt_q == CLK_DIV-2 is the boundary edge.
  assign boundary  = (cnt_q == CNT_BOUND);
  assign en_sample = en_sample_q;

  // Next counter value and strobe: strobe follows the boundary edge by one cycle.
  always_comb begin
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    en_sample_d = boundary;
  end

  // Divider state.
  // NOTE: sequential blocks use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      en_sample_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_sample_q <= en_sample_d;
    end
  end

endmodule

// File: rtl/fir_input_ctrl.sv
// FIR front end: sample strobe, ADC sample retiming onto the strobe,
// shadow/active coefficient banks committed only on sample boundaries,
// and sticky overrun/underrun/bad-address status.
module fir_input_ctrl
  import fir_pkg::*;
#(
  parameter int CLK_DIV = FIR_CLK_DIV,
  parameter int NUM_TAP = FIR_NUM_TAP,
  parameter int DATA_W  = FIR_DATA_W,
  parameter int ADDR_W  = FIR_ADDR_W
) (
  input  logic                      iClk_12M,
  input  logic                      iRst,
  input  logic                      iAdcValid,
  input  logic [DATA_W-1:0]         iAdcData,
  input  logic                      iCoeffValid,
  output logic                      oCoeffReady,
  input  logic [ADDR_W-1:0]         iCoeffAddr,
  input  logic [DATA_W-1:0]         iCoeffData,
  input  logic                      iCoeffCommit,
  input  logic                      iClrStatus,
  output logic                      oEnSample_300k,
  output logic [DATA_W-1:0]         oFirIn,
  output logic [NUM_TAP*DATA_W-1:0] oCoeffBus,
  output logic                      oCoeffUpdated,
  output logic                      oOverrun,
  output logic                      oUnderrun,
  output logic                      oBadAddr
);

  logic boundary;

  // Sample path state.
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] fir_in_q, fir_in_d;
  logic              overrun_evt, underrun_evt;

  // Coefficient state; tap k sits at bits [DATA_W*k +: DATA_W].
  logic [NUM_TAP-1:0][DATA_W-1:0] shadow_q, shadow_d;
  logic [NUM_TAP-1:0][DATA_W-1:0] active_q, active_d;
  logic [0:0]                     state_q, state_d;
  logic                           updated_q, updated_d;
  logic                           coeff_ready, wr_fire, wr_ok, bad_evt;

  // Sticky status.
  logic overrun_q, overrun_d;
  logic underrun_q, underrun_d;
  logic bad_addr_q, bad_addr_d;

  fir_sample_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .clk       (iClk_12M),
    .rst       (iRst),
    .boundary  (boundary),
    .en_sample (oEnSample_300k)
  );

  // Sample retiming: boundary consumes the old pending value before a
  // coincident ADC sample replaces it, so that case is not an overrun.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    fir_in_d     = fir_in_q;
    if (boundary) begin
      if (pend_valid_q) fir_in_d = pend_q;
      pend_valid_d = 1'b0;
    end
    if (iAdcValid) begin
      pend_d       = iAdcData;
      pend_valid_d = 1'b1;
    end
    overrun_evt  = iAdcValid && pend_valid_q && !boundary;
    underrun_evt = boundary && !pend_valid_q;
  end

  // Coefficient write port and commit FSM.
  always_comb begin
    coeff_ready = (state_q == COEFF_IDLE);
    wr_fire     = iCoeffValid && coeff_ready;
    wr_ok       = wr_fire && tap_in_range(int'(iCoeffAddr), NUM_TAP);
    bad_evt     = wr_fire && !wr_ok;
    shadow_d    = shadow_q;
    active_d    = active_q;
    updated_d   = 1'b0;
    state_d     = state_q;
    for (int k = 0; k < NUM_TAP; k++) begin
      if (wr_ok && (int'(iCoeffAddr) == k)) shadow_d[k] = iCoeffData;
    end
    case (state_q)
      COEFF_IDLE: begin
        if (iCoeffCommit) state_d = COEFF_PENDING;
      end
      COEFF_PENDING: begin
        if (boundary) begin
          active_d  = shadow_q;
          updated_d = 1'b1;
          state_d   = COEFF_IDLE;
        end
      end
      default: state_d = COEFF_IDLE;
    endcase
  end

  // Sticky flags: a same-cycle event wins over a clear.
  always_comb begin
    overrun_d  = (overrun_q  && !iClrStatus) || overrun_evt;
    underrun_d = (underrun_q && !iClrStatus) || underrun_evt;
    bad_addr_d = (bad_addr_q && !iClrStatus) || bad_evt;
  end

  // All state, including both coefficient banks.
  // NOTE: the banks are reset because a reset must leave no stale or partial coefficient set.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      fir_in_q     <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      state_q      <= COEFF_IDLE;
      updated_q    <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      bad_addr_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      fir_in_q     <= fir_in_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      state_q      <= state_d;
      updated_q    <= updated_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      bad_addr_q   <= bad_addr_d;
    end
  end

  assign oCoeffReady   = coeff_ready;
  assign oFirIn        = fir_in_q;
  assign oCoeffBus     = active_q;
  assign oCoeffUpdated = updated_q;
  assign oOverrun      = overrun_q;
  assign oUnderrun     = underrun_q;
  assign oBadAddr      = bad_addr_q;

endmodule

// File: tb/tb_fir_input_ctrl.sv
// Directed bench for fir_input_ctrl. Cycle k is the interval after the k-th
// rising edge following reset release (cycle 0 precedes the first edge).
module tb_fir_input_ctrl;

  localparam int NT = 10;
  localparam int DW = 16;

  logic              iClk_12M = 1'b0;
  logic              iRst = 1'b1;
  logic              iAdcValid = 1'b0;
  logic [DW-1:0]     iAdcData = '0;
  logic              iCoeffValid = 1'b0;
  logic              oCoeffReady;
  logic [3:0]        iCoeffAddr = '0;
  logic [DW-1:0]     iCoeffData = '0;
  logic              iCoeffCommit = 1'b0;
  logic              iClrStatus = 1'b0;
  logic              oEnSample_300k;
  logic [DW-1:0]     oFirIn;
  logic [NT*DW-1:0]  oCoeffBus;
  logic              oCoeffUpdated;
  logic              oOverrun;
  logic              oUnderrun;
  logic              oBadAddr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [NT*DW-1:0] exp_bus;

  fir_input_ctrl dut (
    .iClk_12M       (iClk_12M),
    .iRst           (iRst),
    .iAdcValid      (iAdcValid),
    .iAdcData       (iAdcData),
    .iCoeffValid    (iCoeffValid),
    .oCoeffReady    (oCoeffReady),
    .iCoeffAddr     (iCoeffAddr),
    .iCoeffData     (iCoeffData),
    .iCoeffCommit   (iCoeffCommit),
    .iClrStatus     (iClrStatus),
    .oEnSample_300k (oEnSample_300k),
    .oFirIn         (oFirIn),
    .oCoeffBus      (oCoeffBus),
    .oCoeffUpdated  (oCoeffUpdated),
    .oOverrun       (oOverrun),
    .oUnderrun      (oUnderrun),
    .oBadAddr       (oBadAddr)
  );

  always #5 iClk_12M = ~iClk_12M;

  task automatic idle_inputs();
    iAdcValid = 1'b0; iAdcData = '0; iCoeffValid = 1'b0; iCoeffAddr = '0;
    iCoeffData = '0; iCoeffCommit = 1'b0; iClrStatus = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    iRst = 1'b1;
    @(posedge iClk_12M);
    @(posedge iClk_12M);
    @(negedge iClk_12M);
    iRst = 1'b0;
    cyc = 0;
  endtask

  // Advance into the next cycle; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge iClk_12M);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic drive_write(input int addr, input logic [DW-1:0] data);
    iCoeffValid = 1'b1; iCoeffAddr = 4'(addr); iCoeffData = data;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (oEnSample_300k !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", oEnSample_300k); end
    n_cmp++; if (oFirIn !== 16'h0) begin n_err++; $display("FAIL reset_firin: got %h want 0000", oFirIn); end
    n_cmp++; if (oCoeffBus !== '0) begin n_err++; $display("FAIL reset_bus: got %h want 0", oCoeffBus); end
    n_cmp++; if (oCoeffUpdated !== 1'b0) begin n_err++; $display("FAIL reset_updated: got %b want 0", oCoeffUpdated); end
    n_cmp++; if ({oOverrun, oUnderrun, oBadAddr} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {oOverrun, oUnderrun, oBadAddr}); end
    n_cmp++; if (oCoeffReady !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", oCoeffReady); end
  endtask

  task automatic test_strobe();
    do_reset();
    while (cyc <= 125) begin
      n_cmp++;
      if (oEnSample_300k !== ((cyc % 40) == 39)) begin
        n_err++; $display("FAIL strobe_c%0d: got %b want %b", cyc, oEnSample_300k, (cyc % 40) == 39);
      end
      if (cyc == 38) begin
        n_cmp++; if (oUnderrun !== 1'b0) begin n_err++; $display("FAIL underrun_c38: got %b want 0", oUnderrun); end
      end
      if (cyc == 39) begin
        n_cmp++; if (oUnderrun !== 1'b1) begin n_err++; $display("FAIL underrun_c39: got %b want 1", oUnderrun); end
      end
      step();
    end
  endtask

  task automatic test_sample_path();
    do_reset();
    run_to(5); iAdcValid = 1'b1; iAdcData = 16'h1234; step(); idle_inputs();
    run_to(38);
    n_cmp++; if (oFirIn !== 16'h0000) begin n_err++; $display("FAIL sample_c38: got %h want 0000", oFirIn); end
    run_to(39);
    n_cmp++; if (oFirIn !== 16'h1234) begin n_err++; $display("FAIL sample_c39: got %h want 1234", oFirIn); end
    n_cmp++; if (oUnderrun !== 1'b0) begin n_err++; $display("FAIL sample_no_underrun: got %b want 0", oUnderrun); end
    run_to(45); iAdcValid = 1'b1; iAdcData = 16'h1111; step(); idle_inputs();
    run_to(50);
    n_cmp++; if (oOverrun !== 1'b0) begin n_err++; $display("FAIL overrun_c50: got %b want 0", oOverrun); end
    iAdcValid = 1'b1; iAdcData = 16'h2222; step(); idle_inputs();
    n_cmp++; if (oOverrun !== 1'b1) begin n_err++; $display("FAIL overrun_c51: got %b want 1", oOverrun); end
    run_to(78);
    n_cmp++; if (oFirIn !== 16'h1234) begin n_err++; $display("FAIL sample_c78: got %h want 1234", oFirIn); end
    run_to(79);
    n_cmp++; if (oFirIn !== 16'h2222) begin n_err++; $display("FAIL sample_c79: got %h want 2222", oFirIn); end
  endtask

  task automatic test_coincident_sample();
    do_reset();
    run_to(10); iAdcValid = 1'b1; iAdcData = 16'h0001; step(); idle_inputs();
    run_to(38); iAdcValid = 1'b1; iAdcData = 16'h0ABC; step(); idle_inputs();
    n_cmp++; if (oFirIn !== 16'h0001) begin n_err++; $display("FAIL coinc_c39: got %h want 0001", oFirIn); end
    n_cmp++; if (oOverrun !== 1'b0) begin n_err++; $display("FAIL coinc_overrun_c39: got %b want 0", oOverrun); end
    run_to(79);
    n_cmp++; if (oFirIn !== 16'h0ABC) begin n_err++; $display("FAIL coinc_c79: got %h want 0abc", oFirIn); end
    n_cmp++; if ({oOverrun, oUnderrun} !== 2'b00) begin n_err++; $display("FAIL coinc_flags_c79: got %b want 00", {oOverrun, oUnderrun}); end
  endtask

  task automatic test_coeff_commit();
    do_reset();
    for (int k = 0; k < NT; k++) exp_bus[k*DW +: DW] = 16'(k + 1);
    for (int k = 0; k < NT; k++) begin
      drive_write(k, 16'(k + 1));
      n_cmp++; if (oCoeffReady !== 1'b1) begin n_err++; $display("FAIL ready_wr_c%0d: got %b want 1", cyc, oCoeffReady); end
      step();
    end
    idle_inputs();
    iCoeffCommit = 1'b1; step(); idle_inputs();
    while (cyc <= 38) begin
      n_cmp++;
      if ({oCoeffReady, oCoeffUpdated} !== 2'b00 || oCoeffBus !== '0) begin
        n_err++; $display("FAIL pending_c%0d: ready=%b upd=%b bus=%h want ready=0 upd=0 bus=0", cyc, oCoeffReady, oCoeffUpdated, oCoeffBus);
      end
      step();
    end
    n_cmp++; if (oCoeffBus !== exp_bus) begin n_err++; $display("FAIL commit_bus_c39: got %h want %h", oCoeffBus, exp_bus); end
    n_cmp++; if (oCoeffUpdated !== 1'b1) begin n_err++; $display("FAIL commit_upd_c39: got %b want 1", oCoeffUpdated); end
    step();
    n_cmp++; if ({oCoeffReady, oCoeffUpdated} !== 2'b10) begin n_err++; $display("FAIL commit_c40: ready/upd got %b want 10", {oCoeffReady, oCoeffUpdated}); end
    // Write and commit in the same cycle: the write is part of the commit.
    run_to(45); drive_write(3, 16'h7777); iCoeffCommit = 1'b1; step(); idle_inputs();
    exp_bus[3*DW +: DW] = 16'h7777;
    run_to(79);
    n_cmp++; if (oCoeffBus !== exp_bus) begin n_err++; $display("FAIL same_cycle_bus_c79: got %h want %h", oCoeffBus, exp_bus); end
    // Commit on the boundary edge waits for the following boundary.
    run_to(118); drive_write(0, 16'h5555); iCoeffCommit = 1'b1; step(); idle_inputs();
    n_cmp++; if ({oCoeffReady, oCoeffUpdated} !== 2'b00) begin n_err++; $display("FAIL late_commit_c119: ready/upd got %b want 00", {oCoeffReady, oCoeffUpdated}); end
    n_cmp++; if (oCoeffBus !== exp_bus) begin n_err++; $display("FAIL late_commit_bus_c119: got %h want %h", oCoeffBus, exp_bus); end
    // A write while pending is not accepted.
    drive_write(1, 16'h9999); step(); idle_inputs();
    exp_bus[0 +: DW] = 16'h5555;
    run_to(159);
    n_cmp++; if (oCoeffBus !== exp_bus) begin n_err++; $display("FAIL late_commit_bus_c159: got %h want %h", oCoeffBus, exp_bus); end
    n_cmp++; if (oCoeffUpdated !== 1'b1) begin n_err++; $display("FAIL late_commit_upd_c159: got %b want 1", oCoeffUpdated); end
  endtask

  task automatic test_bad_addr();
    do_reset();
    run_to(2); drive_write(12, 16'hDEAD); step(); idle_inputs();
    n_cmp++; if (oBadAddr !== 1'b1) begin n_err++; $display("FAIL bad_set_c3: got %b want 1", oBadAddr); end
    run_to(4); iClrStatus = 1'b1; step(); idle_inputs();
    n_cmp++; if (oBadAddr !== 1'b0) begin n_err++; $display("FAIL bad_clr_c5: got %b want 0", oBadAddr); end
    run_to(6); drive_write(10, 16'hBEEF); iClrStatus = 1'b1; step(); idle_inputs();
    n_cmp++; if (oBadAddr !== 1'b1) begin n_err++; $display("FAIL bad_clr_race_c7: got %b want 1", oBadAddr); end
    run_to(8); iCoeffCommit = 1'b1; step(); idle_inputs();
    run_to(39);
    n_cmp++; if (oCoeffBus !== '0) begin n_err++; $display("FAIL bad_shadow_c39: got %h want 0", oCoeffBus); end
    n_cmp++; if (oCoeffUpdated !== 1'b1) begin n_err++; $display("FAIL bad_upd_c39: got %b want 1", oCoeffUpdated); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    drive_write(0, 16'h4321); step(); idle_inputs();
    run_to(10); iCoeffCommit = 1'b1; step(); idle_inputs();
    run_to(20);
    n_cmp++; if (oCoeffReady !== 1'b0) begin n_err++; $display("FAIL rstp_ready_c20: got %b want 0", oCoeffReady); end
    iRst = 1'b1;
    #1;
    n_cmp++;
    if ({oEnSample_300k, oCoeffUpdated, oOverrun, oUnderrun, oBadAddr} !== 5'b0 || oFirIn !== '0 || oCoeffBus !== '0 || oCoeffReady !== 1'b1) begin
      n_err++; $display("FAIL rstp_async: en=%b upd=%b flags=%b fir=%h bus=%h ready=%b want all 0, ready=1",
        oEnSample_300k, oCoeffUpdated, {oOverrun, oUnderrun, oBadAddr}, oFirIn, oCoeffBus, oCoeffReady);
    end
    do_reset();
    while (cyc <= 45) begin
      n_cmp++;
      if (oCoeffUpdated !== 1'b0 || oCoeffBus !== '0) begin
        n_err++; $display("FAIL rstp_after_c%0d: upd=%b bus=%h want upd=0 bus=0", cyc, oCoeffUpdated, oCoeffBus);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_sample_path();
    test_coincident_sample();
    test_coeff_commit();
    test_bad_addr();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
